// File: rtl/pe_pkg.sv
// Shared types, default parameters and arithmetic helpers for the systolic-array PE.
package pe_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_ACC_W  = 40;
   localparam int unsigned DEF_SIGNED = 1;
   localparam int unsigned DEF_SAT    = 1;

   // Helpers work on a wide scratch vector; ACC_W must stay below MAX_W.
   localparam int unsigned MAX_W = 128;

   typedef logic [MAX_W-1:0] wide_t;

   typedef struct packed {
      logic v;
      logic first;
      logic last;
   } tag_t;

   typedef struct packed {
      logic  ovf;
      wide_t sum;
   } sat_res_t;

   function automatic wide_t width_mask(input int unsigned w);
      return (MAX_W'(1) << w) - MAX_W'(1);
   endfunction

   // Sign- or zero-extend the low w bits of x to the full scratch width.
   function automatic wide_t ext_prod(input wide_t x, input int unsigned w, input logic sgn);
      wide_t m   = width_mask(w);
      logic  msb = |((x >> (w - 1)) & MAX_W'(1));
      return (sgn && msb) ? (x | ~m) : (x & m);
   endfunction

   // w-bit add with overflow detect; clamps to the w-bit limits when sat is set.
   function automatic sat_res_t sat_add(input wide_t base, input wide_t addend,
                                        input int unsigned w, input logic sgn, input logic sat);
      wide_t    m    = width_mask(w);
      wide_t    full = ext_prod(base, w, sgn) + ext_prod(addend, w, sgn);
      wide_t    trnc = full & m;
      sat_res_t r;
      r.ovf = sgn ? (ext_prod(trnc, w, 1'b1) != full) : ((full & ~m) != '0);
      r.sum = trnc;
      if (sat && r.ovf) begin
         if (!sgn)
            r.sum = m;
         else if (full[MAX_W-1])
            r.sum = MAX_W'(1) << (w - 1);
         else
            r.sum = m >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pe_mac_acc.sv
// Accumulate stage: per-tile accumulator with first/last framing and sticky overflow.
module pe_mac_acc
   import pe_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ACC_W  = DEF_ACC_W,
   parameter int unsigned SIGNED = DEF_SIGNED,
   parameter int unsigned SAT    = DEF_SAT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [2*DATA_W-1:0]   prod,
   input  tag_t                  tag,
   output logic [ACC_W-1:0]      acc,
   output logic [ACC_W-1:0]      sum_c,
   output logic                  ovf
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   logic              seen;
   logic              eff_first_c;
   logic [ACC_W-1:0]  base_c;
   sat_res_t          res_c;
   logic [MAX_W-1:ACC_W] sum_hi_unused;

   // Until the first valid item after reset, every item opens a fresh tile.
   always_comb begin
      eff_first_c = tag.first | ~seen;
      base_c      = eff_first_c ? '0 : acc;
      res_c       = sat_add(MAX_W'(base_c), ext_prod(MAX_W'(prod), PROD_W, SIGNED != 0),
                            ACC_W, SIGNED != 0, SAT != 0);
      sum_c       = res_c.sum[ACC_W-1:0];
   end

   assign sum_hi_unused = res_c.sum[MAX_W-1:ACC_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         ovf  <= 1'b0;
         seen <= 1'b0;
      end else if (en && tag.v) begin
         acc  <= sum_c;
         ovf  <= (eff_first_c ? 1'b0 : ovf) | res_c.ovf;
         seen <= 1'b1;
      end
   end

endmodule

// File: rtl/pe_mac_pipe.sv
// Output-stationary systolic PE: operand pass-through, registered multiply,
// tile accumulation and a south-bound drain chain for finished results.
module pe_mac_pipe
   import pe_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ACC_W  = DEF_ACC_W,
   parameter int unsigned SIGNED = DEF_SIGNED,
   parameter int unsigned SAT    = DEF_SAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic              v_in,
   input  logic              first_in,
   input  logic              last_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              v_out,
   output logic              first_out,
   output logic              last_out,
   input  logic [ACC_W-1:0]  c_in,
   input  logic              c_in_v,
   output logic [ACC_W-1:0]  c_out,
   output logic              c_out_v,
   output logic              ovf,
   output logic              err
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   logic [PROD_W-1:0] prod_c;
   logic [PROD_W-1:0] prod_q;
   tag_t              tag_q;
   logic [ACC_W-1:0]  acc_unused;
   logic [ACC_W-1:0]  sum_c;
   logic [ACC_W-1:0]  hold_q;
   logic              hold_v;
   logic              tile_done_c;

   // Low PROD_W bits of the product of sign-extended operands give the signed result.
   always_comb begin
      if (SIGNED != 0)
         prod_c = PROD_W'($signed(a_in)) * PROD_W'($signed(b_in));
      else
         prod_c = PROD_W'(a_in) * PROD_W'(b_in);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_out     <= '0;
         b_out     <= '0;
         v_out     <= 1'b0;
         first_out <= 1'b0;
         last_out  <= 1'b0;
         prod_q    <= '0;
         tag_q     <= '0;
      end else if (en) begin
         a_out     <= a_in;
         b_out     <= b_in;
         v_out     <= v_in;
         first_out <= first_in;
         last_out  <= last_in;
         prod_q    <= prod_c;
         tag_q     <= '{v: v_in, first: first_in, last: last_in};
      end
   end

   pe_mac_acc #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .SIGNED (SIGNED),
      .SAT    (SAT)
   ) u_acc (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .prod  (prod_q),
      .tag   (tag_q),
      .acc   (acc_unused),
      .sum_c (sum_c),
      .ovf   (ovf)
   );

   assign tile_done_c = tag_q.v & tag_q.last;

   // Upstream results always win the drain slot; a held result is lost only
   // when a new one lands while the slot is still taken by c_in.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_out   <= '0;
         c_out_v <= 1'b0;
         hold_q  <= '0;
         hold_v  <= 1'b0;
         err     <= 1'b0;
      end else if (en) begin
         if (c_in_v) begin
            c_out   <= c_in;
            c_out_v <= 1'b1;
         end else if (hold_v) begin
            c_out   <= hold_q;
            c_out_v <= 1'b1;
         end else begin
            c_out_v <= 1'b0;
         end

         if (tile_done_c) begin
            hold_q <= sum_c;
            hold_v <= 1'b1;
            if (hold_v && c_in_v)
               err <= 1'b1;
         end else if (hold_v && !c_in_v) begin
            hold_v <= 1'b0;
         end
      end
   end

endmodule

// File: doc/pe_mac_pipe.md
# pe_mac_pipe

Parametrised, pipelined processing element for the output-stationary systolic array. It is the successor to the current 16-bit PE: it adds configurable operand and accumulator widths, signed/unsigned mode, and a registered multiply stage. It also adds valid-tagged operands, per-tile accumulator clear via `first`/`last` flags, optional saturation, and a column drain chain that shifts finished results toward the array edge without stalling compute. One instance sits at each array node; A flows east, B flows south, and results drain south over the C chain.

## Interface
- `DATA_W`, 16: operand width of A and B.
- `ACC_W`, 40: accumulator and result width; must be at least 2*`DATA_W`.
- `SIGNED`, 1: 1 selects two's-complement operands; 0 selects unsigned.
- `SAT`, 1: 1 clamps the accumulator at its limits; 0 wraps modulo 2^`ACC_W`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high; clears all state.
- `en` in 1: global advance. While low, every register holds its value.
- `a_in` in `DATA_W`: west operand.
- `b_in` in `DATA_W`: north operand.
- `v_in` in 1: operand pair valid.
- `first_in` in 1: this pair starts a new tile.
- `last_in` in 1: this pair ends a tile.
- `a_out` in `DATA_W` direction out: registered `a_in`, to the east neighbour.
- `b_out` out `DATA_W`: registered `b_in`, to the south neighbour.
- `v_out`, `first_out`, `last_out` out 1 each: registered copies of `v_in`, `first_in`, `last_in`.
- `c_in` in `ACC_W`: drain chain input from the north PE.
- `c_in_v` in 1: `c_in` is valid.
- `c_out` out `ACC_W`: drain chain output to the south.
- `c_out_v` out 1: `c_out` is valid.
- `ovf` out 1: sticky flag, set if the current or last tile saturated or wrapped.
- `err` out 1: sticky flag, set when a result was lost; cleared only by `rst`.

## Operation
- **Reset values.** On `rst`, every output and internal register is 0: `a_out`, `b_out`, all flag outputs, `c_out`, `c_out_v`, `ovf`, `err`, the product register, the accumulator, and the hold register.
- **Stage 0 (pass-through).** When `en` is high, the operands and flags are registered to the `*_out` ports unconditionally, whether or not `v_in` is set.
- **Stage 1 (multiply).** Computes `prod = a_in*b_in`, `2*DATA_W` bits wide, signed or unsigned per `SIGNED`. `v`, `first` and `last` are carried alongside the product.
- **Stage 2 (accumulate), valid items only.**
  - The base is 0 if `first` is set, otherwise the accumulator.
  - `sum = base + ext(prod)`, where `ext` sign-extends when `SIGNED`=1 and zero-extends otherwise.
  - Overflow with `SAT`=1: clamp to the maximum or minimum value of `ACC_W` and set `ovf`.
  - Overflow with `SAT`=0: wrap and set `ovf`.
  - `first` clears `ovf` before that item's own overflow is evaluated.
  - An invalid item leaves the accumulator unchanged.
- **Tile end.** On a valid item with `last` set, `sum` is written to the hold register and `hold_v` is set.
- **Single-item tile.** If `first` and `last` are both set on one item, the result is `ext(prod)`.
- **Drain priority.** Each enabled cycle, the upstream `c_in_v` takes priority:
  - If `c_in_v` is high, `c_out` takes `c_in` and `c_out_v` goes to 1.
  - Else if `hold_v` is set, `c_out` takes the hold register and `hold_v` is cleared.
  - Otherwise `c_out_v` goes to 0.
- **Hold conflict.** If a new tile result arrives while `hold_v` is still set, the new result overwrites the hold register and `err` is set.

## Timing
- Pair sampled at edge t (with `en` high at every edge):
  - `a_out`, `b_out` and the flag outputs update at t+1.
  - The product register updates at t+1.
  - The accumulator and hold register update at t+2.
  - The earliest `c_out_v` for the local result is at t+3.
- Throughput is one pair per cycle. Back-to-back tiles are supported: a `last` at cycle t followed by a `first` at t+1 needs no bubble.
- **Stalls.** When `en` is low at an edge, the pipeline is frozen, so latency counts only enabled edges. `c_out_v` holds its value during a stall; the downstream PE must also be stalled.
- **Reset mid-tile.** A partial accumulation and any pending hold result are discarded, with no `err`. The first valid item after reset is treated as having `first` set if the caller omits it.

## Structure
- Shared package `pe_pkg` contains:
  - the default parameter constants;
  - a packed struct for the tag bundle `{v, first, last}`;
  - functions `ext_prod` and `sat_add`, parameterised by width and mode.
- One natural sub-module, `pe_mac_acc`, covering stage 2 and overflow: inputs are the product and tags, outputs are the accumulator, `sum`, and overflow. The pass-through, product register and drain logic stay in the top module.

## Test plan
- **Unsigned basic.** `SIGNED`=0: feed pairs (3,4), (5,6) with `first` on the first pair and `last` on the second → `c_out`=42 with `c_out_v` high at t0+4; `a_out`=3 at t0+1.
- **Signed single item.** `SIGNED`=1: one pair (-2,7) with `first` and `last` both set → `c_out`=-14 (sign-extended to 40 bits), `ovf`=0.
- **Saturation vs wrap.** `ACC_W`=32, `SAT`=1, `SIGNED`=1: accumulate 32767*32767 three times → `c_out`=0x7FFFFFFF, `ovf`=1. With `SAT`=0 and the same stimulus → the wrapped value, `ovf`=1.
- **Drain contention.** `c_in_v` high for 3 cycles with `c_in`=11,12,13, and a local result of 99 arriving in the first of those cycles → `c_out` sequence 11, 12, 13, 99, with `err`=0.
- **Hold loss.** Tiles of length 1 back-to-back while `c_in_v` is held high → `err`=1, and the hold register contains the later result.
- **Stall and reset.** `en` low for 5 cycles mid-tile → the final result matches the unstalled run. `rst` mid-tile → all outputs 0 next cycle, and the next tile's result is uncontaminated.
